// File: rtl/m6502_bus_ctrl_pkg.sv
// Shared definitions for the m6502 memory-side bus controller: region codes,
// controller state encoding and the region -> one-hot select mapping.
package m6502_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    REGION_RAM = 2'd0,
    REGION_ROM = 2'd1,
    REGION_IO  = 2'd2
  } region_e;

  typedef enum logic {
    BUS_IDLE   = 1'b0,
    BUS_ACCESS = 1'b1
  } bus_state_e;

  // Select vector ordering is {io, rom, ram}.
  function automatic logic [2:0] region_onehot(input region_e r);
    logic [2:0] sel;
    case (r)
      REGION_IO:  sel = 3'b100;
      REGION_ROM: sel = 3'b010;
      default:    sel = 3'b001;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/m6502_region_decode.sv
// Combinational address decode: IO page first, then ROM window, else RAM,
// together with that region's read wait-state count.
module m6502_region_decode
  import m6502_bus_ctrl_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = 16'hE000,
  parameter logic [7:0]  IO_PAGE  = 8'hD0,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic [15:0] addr,
  output region_e     region,
  output logic [3:0]  wait_cnt
);

  // The wait counter is 4 bits wide; larger values could never be counted out.
  if (RAM_WAIT > 15 || ROM_WAIT > 15 || IO_WAIT > 15) begin : g_bad_wait
    $error("m6502_region_decode: wait-state parameters must be 0..15");
  end

  always_comb begin
    region   = REGION_RAM;
    wait_cnt = 4'(RAM_WAIT);
    if (addr[15:8] == IO_PAGE) begin
      region   = REGION_IO;
      wait_cnt = 4'(IO_WAIT);
    end else if (addr >= ROM_BASE) begin
      region   = REGION_ROM;
      wait_cnt = 4'(ROM_WAIT);
    end
  end

endmodule

// File: rtl/m6502_bus_ctrl.sv
// Memory-side bus controller for the m6502 core: decodes requests into RAM/ROM/IO
// accesses, inserts per-region read wait states and returns read data to the core.
module m6502_bus_ctrl
  import m6502_bus_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2,
  parameter logic [15:0] ROM_BASE = 16'hE000,
  parameter logic [7:0]  IO_PAGE  = 8'hD0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_en,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ram_sel,
  output logic        rom_sel,
  output logic        io_sel,
  input  logic [7:0]  ram_rd_data,
  input  logic [7:0]  rom_rd_data,
  input  logic [7:0]  io_rd_data,
  output logic        rom_wr_fault,
  output logic        proto_err,
  output bus_state_e  dbg_state
);

  // Handshake: the core may pulse cpu_rd_req or cpu_wr_en only while cpu_ready=1;
  // a read holds cpu_ready low until the edge that loads cpu_rd_data, writes never
  // drop it, and any request made while cpu_ready=0 is ignored and flagged.

  bus_state_e state_q, state_d;
  region_e    region_q, region_d, dec_region;
  logic [3:0] cnt_q, cnt_d, dec_wait;
  logic [2:0] sel_q, sel_d;
  logic [7:0] rd_data_d, wr_data_d;
  logic [15:0] addr_d;
  logic       ready_d, mem_rd_d, mem_wr_d, fault_d, perr_d;

  m6502_region_decode #(
    .ROM_BASE(ROM_BASE), .IO_PAGE(IO_PAGE),
    .RAM_WAIT(RAM_WAIT), .ROM_WAIT(ROM_WAIT), .IO_WAIT(IO_WAIT)
  ) u_decode (
    .addr    (cpu_addr),
    .region  (dec_region),
    .wait_cnt(dec_wait)
  );

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    cnt_d     = cnt_q;
    ready_d   = cpu_ready;
    rd_data_d = cpu_rd_data;
    addr_d    = mem_addr;
    wr_data_d = mem_wr_data;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    sel_d     = 3'b000;
    fault_d   = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (cpu_wr_en) begin
          // A read arriving with a write is dropped; the write still goes out.
          perr_d = cpu_rd_req;
          if (dec_region == REGION_ROM) begin
            fault_d = 1'b1;
          end else begin
            mem_wr_d  = 1'b1;
            sel_d     = region_onehot(dec_region);
            addr_d    = cpu_addr;
            wr_data_d = cpu_wr_data;
          end
        end else if (cpu_rd_req) begin
          mem_rd_d = 1'b1;
          sel_d    = region_onehot(dec_region);
          addr_d   = cpu_addr;
          region_d = dec_region;
          cnt_d    = dec_wait;
          ready_d  = 1'b0;
          state_d  = BUS_ACCESS;
        end
      end
      default: begin
        perr_d = cpu_rd_req | cpu_wr_en;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          case (region_q)
            REGION_IO:  rd_data_d = io_rd_data;
            REGION_ROM: rd_data_d = rom_rd_data;
            default:    rd_data_d = ram_rd_data;
          endcase
          ready_d = 1'b1;
          state_d = BUS_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BUS_IDLE;
      region_q     <= REGION_RAM;
      cnt_q        <= 4'd0;
      cpu_ready    <= 1'b1;
      cpu_rd_data  <= 8'h00;
      mem_addr     <= 16'h0000;
      mem_wr_data  <= 8'h00;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      sel_q        <= 3'b000;
      rom_wr_fault <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      cnt_q        <= cnt_d;
      cpu_ready    <= ready_d;
      cpu_rd_data  <= rd_data_d;
      mem_addr     <= addr_d;
      mem_wr_data  <= wr_data_d;
      mem_rd       <= mem_rd_d;
      mem_wr       <= mem_wr_d;
      sel_q        <= sel_d;
      rom_wr_fault <= fault_d;
      proto_err    <= perr_d;
    end
  end

  assign {io_sel, rom_sel, ram_sel} = sel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_m6502_bus_ctrl.sv
// Bench for m6502_bus_ctrl: directed vector table, hand-written reset/protocol
// sequences and randomized transactions checked against a transaction-level model.
module tb_m6502_bus_ctrl;
  import m6502_bus_ctrl_pkg::*;

  localparam int unsigned RAM_WAIT = 0;
  localparam int unsigned ROM_WAIT = 1;
  localparam int unsigned IO_WAIT  = 2;
  localparam logic [15:0] ROM_BASE = 16'hE000;
  localparam logic [7:0]  IO_PAGE  = 8'hD0;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_BOTH = 2'd2;

  logic        clk, reset;
  logic [15:0] cpu_addr;
  logic        cpu_rd_req, cpu_wr_en;
  logic [7:0]  cpu_wr_data, cpu_rd_data;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_rd, mem_wr, ram_sel, rom_sel, io_sel;
  logic [7:0]  ram_rd_data, rom_rd_data, io_rd_data;
  logic        rom_wr_fault, proto_err;
  bus_state_e  dbg_state;

  m6502_bus_ctrl #(
    .RAM_WAIT(RAM_WAIT), .ROM_WAIT(ROM_WAIT), .IO_WAIT(IO_WAIT),
    .ROM_BASE(ROM_BASE), .IO_PAGE(IO_PAGE)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd_req(cpu_rd_req), .cpu_wr_en(cpu_wr_en),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ram_sel(ram_sel), .rom_sel(rom_sel), .io_sel(io_sel),
    .ram_rd_data(ram_rd_data), .rom_rd_data(rom_rd_data), .io_rd_data(io_rd_data),
    .rom_wr_fault(rom_wr_fault), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Region rules: IO page wins, then ROM window, else RAM. A read keeps ready
  // low for WAIT+1 cycles; a ROM write is dropped and produces a fault pulse.
  function automatic void model(input logic [15:0] a, output logic [2:0] sel, output int lat);
    if (a[15:8] == IO_PAGE) begin
      sel = 3'b100; lat = int'(IO_WAIT) + 1;
    end else if (a >= ROM_BASE) begin
      sel = 3'b010; lat = int'(ROM_WAIT) + 1;
    end else begin
      sel = 3'b001; lat = int'(RAM_WAIT) + 1;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic set_devices(input logic [2:0] sel, input logic [7:0] d);
    ram_rd_data = (sel == 3'b001) ? d : d ^ 8'hFF;
    rom_rd_data = (sel == 3'b010) ? d : d ^ 8'h5A;
    io_rd_data  = (sel == 3'b100) ? d : d ^ 8'hC3;
  endtask

  task automatic do_txn(input string tag, input logic [15:0] addr, input logic [1:0] op,
                        input logic poke, input logic [7:0] data, input logic [2:0] exp_sel,
                        input int exp_lat, input logic exp_fault);
    int lat;
    logic first;
    logic [7:0] exp_d;
    if (op == OP_RD) begin
      set_devices(exp_sel, data);
      exp_q.push_back(data);
      cpu_addr = addr;
      cpu_rd_req = 1'b1;
      @(posedge clk); #1;
      cpu_rd_req = 1'b0;
      chk({tag, " mem_rd"}, 16'(mem_rd), 16'd1);
      chk({tag, " rd_sel"}, 16'({io_sel, rom_sel, ram_sel}), 16'(exp_sel));
      chk({tag, " rd_addr"}, mem_addr, addr);
      chk({tag, " ready_low"}, 16'(cpu_ready), 16'd0);
      if (poke) begin
        cpu_addr = ~addr;
        if ($urandom_range(0, 1) == 1) cpu_wr_en = 1'b1;
        else cpu_rd_req = 1'b1;
      end
      lat = 1;
      first = 1'b1;
      while (cpu_ready == 1'b0 && lat < 40) begin
        @(posedge clk); #1;
        cpu_rd_req = 1'b0;
        cpu_wr_en = 1'b0;
        if (first) begin
          chk({tag, " proto_err"}, 16'(proto_err), 16'(poke));
          chk({tag, " strobe_1cyc"}, 16'({mem_rd, mem_wr, io_sel, rom_sel, ram_sel}), 16'd0);
          first = 1'b0;
        end
        if (cpu_ready == 1'b0) lat++;
      end
      chk({tag, " latency"}, 16'(lat), 16'(exp_lat));
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk({tag, " rd_data"}, 16'(cpu_rd_data), 16'(exp_d));
      chk({tag, " addr_hold"}, mem_addr, addr);
    end else begin
      set_devices(3'b000, data);
      cpu_addr = addr;
      cpu_wr_data = data;
      cpu_wr_en = 1'b1;
      cpu_rd_req = (op == OP_BOTH);
      @(posedge clk); #1;
      cpu_wr_en = 1'b0;
      cpu_rd_req = 1'b0;
      chk({tag, " mem_wr"}, 16'(mem_wr), 16'(exp_sel != 3'b000));
      chk({tag, " wr_sel"}, 16'({io_sel, rom_sel, ram_sel}), 16'(exp_sel));
      chk({tag, " rom_fault"}, 16'(rom_wr_fault), 16'(exp_fault));
      chk({tag, " wr_ready"}, 16'({cpu_ready, mem_rd}), 16'b10);
      chk({tag, " wr_proto"}, 16'(proto_err), 16'(op == OP_BOTH));
      if (exp_sel != 3'b000) begin
        chk({tag, " wr_addr"}, mem_addr, addr);
        chk({tag, " wr_data"}, 16'(mem_wr_data), 16'(data));
      end
      @(posedge clk); #1;
      chk({tag, " wr_after"}, 16'({cpu_ready, mem_wr, mem_rd, rom_wr_fault, proto_err}), 16'b10000);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] addr;
    logic [1:0]  op;
    logic        poke;
    logic [7:0]  data;
    logic [2:0]  exp_sel;
    int          exp_lat;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [15:0] a;
    logic [1:0]  op;
    logic [2:0]  sel;
    int          lat;
    logic        poke;

    vecs[0]  = '{16'h0200, OP_RD,   1'b0, 8'hA5, 3'b001, 1, 1'b0};
    vecs[1]  = '{16'hFFFC, OP_RD,   1'b0, 8'h34, 3'b010, 2, 1'b0};
    vecs[2]  = '{16'hD010, OP_RD,   1'b0, 8'h5C, 3'b100, 3, 1'b0};
    vecs[3]  = '{16'h0300, OP_WR,   1'b0, 8'h42, 3'b001, 0, 1'b0};
    vecs[4]  = '{16'hE000, OP_WR,   1'b0, 8'h42, 3'b000, 0, 1'b1};
    vecs[5]  = '{16'hDFFF, OP_RD,   1'b0, 8'h11, 3'b001, 1, 1'b0};
    vecs[6]  = '{16'hE000, OP_RD,   1'b0, 8'h22, 3'b010, 2, 1'b0};
    vecs[7]  = '{16'hD0FF, OP_RD,   1'b0, 8'h33, 3'b100, 3, 1'b0};
    vecs[8]  = '{16'hD100, OP_RD,   1'b0, 8'h44, 3'b001, 1, 1'b0};
    vecs[9]  = '{16'hCFFF, OP_RD,   1'b0, 8'h55, 3'b001, 1, 1'b0};
    vecs[10] = '{16'hD0AA, OP_WR,   1'b0, 8'h66, 3'b100, 0, 1'b0};
    vecs[11] = '{16'hFFFF, OP_WR,   1'b0, 8'h77, 3'b000, 0, 1'b1};
    vecs[12] = '{16'h0400, OP_BOTH, 1'b0, 8'h88, 3'b001, 0, 1'b0};
    vecs[13] = '{16'hE123, OP_BOTH, 1'b0, 8'h99, 3'b000, 0, 1'b1};
    vecs[14] = '{16'h0200, OP_RD,   1'b1, 8'h6B, 3'b001, 1, 1'b0};
    vecs[15] = '{16'hD010, OP_RD,   1'b1, 8'hE7, 3'b100, 3, 1'b0};

    reset = 1'b1;
    cpu_addr = 16'h0000;
    cpu_rd_req = 1'b0;
    cpu_wr_en = 1'b0;
    cpu_wr_data = 8'h00;
    set_devices(3'b000, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready/rd_data", {7'd0, cpu_ready, cpu_rd_data}, 16'h0100);
    chk("reset mem_addr", mem_addr, 16'h0000);
    chk("reset mem_wr_data", 16'(mem_wr_data), 16'h0000);
    chk("reset strobes", 16'({mem_rd, mem_wr, io_sel, rom_sel, ram_sel, rom_wr_fault, proto_err}), 16'd0);
    chk("reset state", 16'(dbg_state), 16'(BUS_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].op, vecs[i].poke, vecs[i].data,
             vecs[i].exp_sel, vecs[i].exp_lat, vecs[i].exp_fault);
    end

    // Reset during the first ACCESS cycle of an IO read aborts it outright.
    do_txn("pre_rst", 16'h0123, OP_RD, 1'b0, 8'h96, 3'b001, 1, 1'b0);
    set_devices(3'b100, 8'hC3);
    cpu_addr = 16'hD010;
    cpu_rd_req = 1'b1;
    @(posedge clk); #1;
    cpu_rd_req = 1'b0;
    chk("rst_mid in_access", 16'(dbg_state), 16'(BUS_ACCESS));
    reset = 1'b1;
    #1;
    chk("rst_mid ready/rd_data", {7'd0, cpu_ready, cpu_rd_data}, 16'h0100);
    chk("rst_mid strobes", 16'({mem_rd, mem_wr, io_sel, rom_sel, ram_sel}), 16'd0);
    chk("rst_mid mem_addr", mem_addr, 16'h0000);
    chk("rst_mid state", 16'(dbg_state), 16'(BUS_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_txn("post_rst", 16'h0200, OP_RD, 1'b0, 8'h3C, 3'b001, 1, 1'b0);

    // Randomized transactions against the model.
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 3) == 0) a[15:8] = IO_PAGE;
      op = 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
      poke = (op == OP_RD) && ($urandom_range(0, 3) == 0);
      model(a, sel, lat);
      if (op == OP_RD)
        do_txn("rnd", a, op, poke, 8'($urandom_range(0, 255)), sel, lat, 1'b0);
      else
        do_txn("rnd", a, op, 1'b0, 8'($urandom_range(0, 255)),
               (sel == 3'b010) ? 3'b000 : sel, 0, sel == 3'b010);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
